// File: rtl/cache_pkg.sv
// Shared types, default widths and address-split helpers for the
// direct-mapped, one-word-per-line cache.
package cache_pkg;

  localparam int DEF_INDEX_W = 5;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_INDEX_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR,
    FLUSH,
    DONE
  } state_t;

  // Line index of a byte address: the word offset bits [1:0] are skipped.
  function automatic logic [DEF_INDEX_W-1:0] index_of(input logic [DEF_ADDR_W-1:0] addr);
    return addr[DEF_INDEX_W+1:2];
  endfunction

  function automatic logic [DEF_TAG_W-1:0] tag_of(input logic [DEF_ADDR_W-1:0] addr);
    return addr[DEF_ADDR_W-1:DEF_INDEX_W+2];
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU port, memory port and array-side signals of the cache controller.
// master is the controller's view; slave is the view of its surroundings.
interface cache_controller_if
  import cache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int ADDR_W  = DEF_ADDR_W
) ();

  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  logic               cpu_req;
  logic               cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [31:0]        cpu_wdata;
  logic [31:0]        cpu_rdata;
  logic               cpu_ready;

  logic               flush;
  logic               flush_done;

  logic [INDEX_W-1:0] idx;
  logic               valid_rd;
  logic               valid_we;
  logic               valid_wd;
  logic [TAG_W-1:0]   tag_rd;
  logic               tag_we;
  logic [TAG_W-1:0]   tag_wd;
  logic [31:0]        data_rd;
  logic               data_we;
  logic [31:0]        data_wd;

  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
  logic               mem_ready;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
    input  valid_rd, tag_rd, data_rd, mem_rdata, mem_ready,
    output cpu_rdata, cpu_ready, flush_done, idx,
    output valid_we, valid_wd, tag_we, tag_wd, data_we, data_wd,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
    output valid_rd, tag_rd, data_rd, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_ready, flush_done, idx,
    input  valid_we, valid_wd, tag_we, tag_wd, data_we, data_wd,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped write-through cache: read-allocate,
// no write-allocate, plus a whole-cache invalidate walk.
module cache_controller
  import cache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.master bus
);

  localparam int TAG_W  = ADDR_W - INDEX_W - 2;
  localparam int LINE_W = ADDR_W - 2;

  state_t             state_reg, state_next;
  logic [INDEX_W-1:0] fcnt_reg, fcnt_next;
  logic [LINE_W-1:0]  line_reg, line_next;
  logic               we_reg, we_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic [31:0]        rdata_reg, rdata_next;

  logic [INDEX_W-1:0] line_idx;
  logic [TAG_W-1:0]   line_tag;
  logic               hit;

  // Only the word address is kept; the memory address is rebuilt word-aligned.
  assign line_idx = line_reg[INDEX_W-1:0];
  assign line_tag = line_reg[LINE_W-1:INDEX_W];
  assign hit      = bus.valid_rd && (bus.tag_rd == line_tag);

  assign bus.cpu_rdata = rdata_reg;
  assign bus.mem_addr  = {line_reg, 2'b00};
  assign bus.mem_wdata = wdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      fcnt_reg  <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
      rdata_reg <= rdata_next;
    end
    line_reg  <= line_next;
    we_reg    <= we_next;
    wdata_reg <= wdata_next;
  end

  always_comb begin
    state_next     = state_reg;
    fcnt_next      = fcnt_reg;
    line_next      = line_reg;
    we_next        = we_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    bus.idx        = line_idx;
    bus.cpu_ready  = 1'b0;
    bus.flush_done = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.valid_we   = 1'b0;
    bus.valid_wd   = 1'b0;
    bus.tag_we     = 1'b0;
    bus.tag_wd     = line_tag;
    bus.data_we    = 1'b0;
    bus.data_wd    = wdata_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.flush) begin
          state_next = FLUSH;
          fcnt_next  = '0;
        end else if (bus.cpu_req) begin
          line_next  = bus.cpu_addr[ADDR_W-1:2];
          we_next    = bus.cpu_we;
          wdata_next = bus.cpu_wdata;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (we_reg) begin
          // Stores always go through to memory; only a hit updates the line.
          bus.data_we = hit;
          state_next  = MEM_WR;
        end else if (hit) begin
          rdata_next = bus.data_rd;
          state_next = DONE;
        end else begin
          state_next = MEM_RD;
        end
      end
      MEM_RD: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.valid_we = 1'b1;
          bus.valid_wd = 1'b1;
          bus.tag_we   = 1'b1;
          bus.data_we  = 1'b1;
          bus.data_wd  = bus.mem_rdata;
          rdata_next   = bus.mem_rdata;
          state_next   = DONE;
        end
      end
      MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ready) begin
          state_next = DONE;
        end
      end
      FLUSH: begin
        bus.idx      = fcnt_reg;
        bus.valid_we = 1'b1;
        if (fcnt_reg == '1) begin
          bus.flush_done = 1'b1;
          state_next     = IDLE;
        end else begin
          fcnt_next = fcnt_reg + 1'b1;
        end
      end
      DONE: begin
        bus.cpu_ready = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
